// File: rtl/sbox_byte_seq.sv
// Byte-serial SubBytes/InvSubBytes sequencer driving one shared S-box unit.
// Define SBOX_SEQ_PIPE_EN when the shared S-box has one output register stage.
module sbox_byte_seq #(
    parameter int N_BYTES = 16,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*N_BYTES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*N_BYTES-1:0] out_data,
    output logic                 sbox_en,
    output logic                 sbox_inv,
    output logic [7:0]           sbox_in,
    input  logic [7:0]           sbox_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BYTES - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_live;
    logic                        r_mode;
    logic [CNT_W-1:0]            r_cnt;
    logic [N_BYTES-1:0][7:0]     r_data;
    logic [N_BYTES-1:0][7:0]     r_result;

    logic                        w_accept;
    logic                        w_last;
    logic                        w_issue;
    logic                        w_run_end;

    assign w_accept = (r_state == S_IDLE) && r_live && in_valid && !flush;
    assign w_last   = (r_cnt == LAST);

`ifdef SBOX_SEQ_PIPE_EN
    // Extra RUN cycle drains the byte still inside the S-box register.
    logic                        r_drain;
    logic                        r_vld_p1;
    logic [CNT_W-1:0]            r_idx_p1;

    assign w_issue   = (r_state == S_RUN) && !r_drain;
    assign w_run_end = (r_state == S_RUN) && r_drain;
`else
    assign w_issue   = (r_state == S_RUN);
    assign w_run_end = (r_state == S_RUN) && w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_run_end) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE) && r_live;
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_RUN) || (r_state == S_DONE);
        sbox_en   = w_issue;
        sbox_inv  = w_issue ? r_mode : 1'b0;
        sbox_in   = w_issue ? r_data[r_cnt] : 8'h00;
        out_data  = r_result;
    end

    // in_ready is held low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
`ifdef SBOX_SEQ_PIPE_EN
            r_drain  <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_idx_p1 <= '0;
`endif
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_cnt <= '0;
`ifdef SBOX_SEQ_PIPE_EN
                r_drain  <= 1'b0;
                r_vld_p1 <= 1'b0;
`endif
            end else begin
                if (w_accept) begin
                    r_cnt  <= '0;
                    r_mode <= in_inv;
                end else if (r_state == S_RUN) begin
`ifdef SBOX_SEQ_PIPE_EN
                    if (r_drain) begin
                        r_drain <= 1'b0;
                    end else if (w_last) begin
                        r_drain <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
`ifdef SBOX_SEQ_PIPE_EN
                r_vld_p1 <= w_issue;
                r_idx_p1 <= r_cnt;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_data <= in_data;
            end
`ifdef SBOX_SEQ_PIPE_EN
            if ((r_state == S_RUN) && r_vld_p1 && !flush) begin
                r_result[r_idx_p1] <= sbox_out;
            end
`else
            if ((r_state == S_RUN) && !flush) begin
                r_result[r_cnt] <= sbox_out;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sbox_byte_seq.sv
// Bench for sbox_byte_seq: supplies a computed AES S-box on the shared port
// and scores results against known SubBytes/InvSubBytes vectors.
module tb_sbox_byte_seq;

    localparam int NB = 16;
`ifdef SBOX_SEQ_PIPE_EN
    localparam int LAT = NB + 1;
`else
    localparam int LAT = NB;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_inv;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic          sbox_en;
    logic          sbox_inv;
    logic [7:0]    sbox_in;
    logic [7:0]    sbox_out;
    logic          busy;

    int checks;
    int failures;
    logic [127:0] sb_q[$];

    typedef struct {
        logic         inv;
        logic [127:0] data;
        logic [127:0] exp;
        int           hold;
        bit           toggle;
    } vec_t;

    vec_t vecs[4];

    sbox_byte_seq #(.N_BYTES(NB), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sbox_en   (sbox_en),
        .sbox_inv  (sbox_inv),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        if (x == 8'h00) return 8'h00;
        r = 8'h01;
        p = x;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sb_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sb_inv(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    logic [7:0] w_sb;
    always_comb w_sb = sbox_inv ? sb_inv(sbox_in) : sb_fwd(sbox_in);

`ifdef SBOX_SEQ_PIPE_EN
    always @(posedge clk) sbox_out <= w_sb;
`else
    always_comb sbox_out = w_sb;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_wait", 128'(in_ready), 128'(1));
    endtask

    // Leaves the caller 1ns after the accepting edge.
    task automatic send(input logic inv, input logic [127:0] data);
        wait_ready();
        in_valid = 1'b1;
        in_inv   = inv;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int en;
        bit seen;
        bit inv_bad;
        logic [127:0] snap;
        logic [127:0] exp;
        send(v.inv, v.data);
        sb_q.push_back(v.exp);
        n = 0;
        en = 0;
        seen = 0;
        inv_bad = 0;
        while (!seen && n <= LAT + 5) begin
            @(negedge clk);
            if (v.toggle) in_inv = ~in_inv;
            if (sbox_en) begin
                en++;
                if (sbox_inv !== v.inv) inv_bad = 1;
            end
            if (out_valid) seen = 1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        in_inv = 1'b0;
        chk("latency", 128'(n), 128'(LAT));
        chk("sbox_en_cycles", 128'(en), 128'(NB));
        chk("sbox_inv_run", 128'(inv_bad), 128'(0));
        snap = out_data;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            chk("bp_flags", 128'({out_valid, in_ready, busy}), 128'(3'b101));
            chk("bp_data", out_data, snap);
        end
        out_ready = 1'b1;
        if (sb_q.size() == 0) begin
            chk("sb_q_empty", 128'(0), 128'(1));
        end else begin
            exp = sb_q.pop_front();
            chk("out_data", out_data, exp);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ov_seen;
        vec_t v;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0] = '{1'b1, {16{8'h63}}, 128'h0, 0, 1'b0};
        vecs[1] = '{1'b0, 128'h00112233445566778899aabbccddeeff,
                    128'h638293c31bfc33f5c4eeacea4bc12816, 0, 1'b0};
        vecs[2] = '{1'b1, 128'h638293c31bfc33f5c4eeacea4bc12816,
                    128'h00112233445566778899aabbccddeeff, 5, 1'b0};
        vecs[3] = '{1'b1, {16{8'h7c}}, {16{8'h01}}, 0, 1'b1};

        // Power-on reset values
        #12;
        chk("rst_ctrl", 128'({in_ready, out_valid, sbox_en, sbox_inv, busy}), 128'(0));
        chk("rst_sbox_in", 128'(sbox_in), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("rel_in_ready_post", 128'(in_ready), 128'(1));

        // Vector table; entry 2 applies backpressure, entry 3 follows it directly
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Flush at cnt=7
        send(1'b0, 128'h0f0e0d0c0b0a09080706050403020100);
        repeat (7) @(posedge clk);
        #1;
        chk("flush_sbox_in", 128'({sbox_en, sbox_in}), 128'({1'b1, 8'h07}));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle", 128'({busy, in_ready, sbox_en, out_valid}), 128'(4'b0100));
        ov_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1;
        end
        chk("flush_no_out", 128'(ov_seen), 128'(0));

        // Flush concurrent with a request in IDLE drops the request
        in_valid = 1'b1;
        in_inv   = 1'b1;
        in_data  = {16{8'haa}};
        flush    = 1'b1;
        #1;
        chk("flush_req_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_inv   = 1'b0;
        chk("flush_req_dropped", 128'({busy, sbox_en}), 128'(0));

        v = '{1'b1, {16{8'h7c}}, {16{8'h01}}, 0, 1'b0};
        run_vec(v);

        // Asynchronous reset at cnt=3, between edges
        send(1'b1, {16{8'h63}});
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_run", 128'({busy, sbox_en, sbox_inv}), 128'(3'b111));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 128'({in_ready, out_valid, sbox_en, sbox_inv, busy}), 128'(0));
        chk("arst_sbox_in", 128'(sbox_in), 128'(0));
        chk("arst_out_data", out_data, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arel_in_ready_pre", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("arel_in_ready_post", 128'(in_ready), 128'(1));

        v = '{1'b0, {16{8'h53}}, {16{8'hed}}, 0, 1'b0};
        run_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
